// File: rtl/dram_master.sv
// dram_master: single-request initiator for the multiplexed 8-bit DRAM bus.
// Drives row (addr[7:0]) then column (addr[15:8]) on maddress under _ras/_cas,
// and interleaves RAS-only refresh from a free-running period counter.
module dram_master #(
  parameter int unsigned T_RCD          = 2,
  parameter int unsigned T_CAS          = 2,
  parameter int unsigned T_RP           = 2,
  parameter int unsigned T_RAS_REF      = 3,
  parameter int unsigned REFRESH_PERIOD = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic [7:0]  maddress,
  output logic        _ras,
  output logic        _cas,
  output logic        _we,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);

  localparam int unsigned TMaxA = (T_RCD > T_CAS) ? T_RCD : T_CAS;
  localparam int unsigned TMaxB = (T_RP > T_RAS_REF) ? T_RP : T_RAS_REF;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned PhW   = $clog2(TMax + 1);
  localparam int unsigned RefW  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  typedef enum logic [2:0] {StIdle, StRas, StCas, StRef, StPre} state_e;

  state_e          state_q, state_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic [15:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic [7:0]      ref_row_q, ref_row_d;
  logic            pend_q, pend_d;
  logic            ref_wrap;

  logic       ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic [7:0] maddr_q, maddr_d, dout_q, dout_d, rdata_q, rdata_d;
  logic       oe_q, oe_d, ack_q, ack_d, rv_q, rv_d, busy_q, busy_d;

  assign ref_wrap = (ref_cnt_q == RefW'(REFRESH_PERIOD - 1));

  // Next-state: phase sequencing, request capture, refresh bookkeeping.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ref_row_d = ref_row_q;
    pend_d    = pend_q;
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RefW'(1);
    unique case (state_q)
      StIdle: begin
        // Refresh has priority; a concurrent request simply waits.
        if (pend_q) begin
          state_d = StRef;
          phase_d = PhW'(T_RAS_REF - 1);
          pend_d  = 1'b0;
        end else if (req) begin
          state_d = StRas;
          phase_d = PhW'(T_RCD - 1);
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
        end
      end
      StRas: begin
        if (phase_q == '0) begin
          state_d = StCas;
          phase_d = PhW'(T_CAS - 1);
        end else begin
          phase_d = phase_q - PhW'(1);
        end
      end
      StCas: begin
        if (phase_q == '0) begin
          state_d = StPre;
          phase_d = PhW'(T_RP - 1);
        end else begin
          phase_d = phase_q - PhW'(1);
        end
      end
      StRef: begin
        if (phase_q == '0) begin
          state_d   = StPre;
          phase_d   = PhW'(T_RP - 1);
          ref_row_d = ref_row_q + 8'd1;
        end else begin
          phase_d = phase_q - PhW'(1);
        end
      end
      StPre: begin
        if (phase_q == '0) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q - PhW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // A wrap always leaves exactly one refresh owed, even on the REF entry cycle.
    if (ref_wrap) begin
      pend_d = 1'b1;
    end
  end

  // Registered outputs are decoded from the upcoming state so strobes align with phases.
  always_comb begin
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    maddr_d = maddr_q;
    dout_d  = 8'h00;
    oe_d    = 1'b0;
    rdata_d = rdata_q;
    busy_d  = (state_d != StIdle);
    ack_d   = (state_q == StCas) && (state_d == StPre);
    rv_d    = ack_d && !we_q;
    if (rv_d) begin
      rdata_d = data_in;
    end
    unique case (state_d)
      StRas: begin
        ras_n_d = 1'b0;
        maddr_d = addr_d[7:0];
      end
      StCas: begin
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        maddr_d = addr_d[15:8];
        we_n_d  = ~we_d;
        oe_d    = we_d;
        dout_d  = we_d ? wdata_d : 8'h00;
      end
      StRef: begin
        ras_n_d = 1'b0;
        maddr_d = ref_row_q;
      end
      StIdle, StPre: ;
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ref_cnt_q <= '0;
      ref_row_q <= '0;
      pend_q    <= 1'b0;
      ras_n_q   <= 1'b1;
      cas_n_q   <= 1'b1;
      we_n_q    <= 1'b1;
      maddr_q   <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      rv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ref_cnt_q <= ref_cnt_d;
      ref_row_q <= ref_row_d;
      pend_q    <= pend_d;
      ras_n_q   <= ras_n_d;
      cas_n_q   <= cas_n_d;
      we_n_q    <= we_n_d;
      maddr_q   <= maddr_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      rv_q      <= rv_d;
      busy_q    <= busy_d;
    end
  end

  assign _ras        = ras_n_q;
  assign _cas        = cas_n_q;
  assign _we         = we_n_q;
  assign maddress    = maddr_q;
  assign data_out    = dout_q;
  assign data_oe     = oe_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign ack         = ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dram_master.sv
// Directed bench for dram_master: a default-timing instance exercises accesses,
// reset abort and refresh collision; a fast-refresh instance checks row wrap.
module tb_dram_master;

  localparam int unsigned TRcd       = 2;
  localparam int unsigned TCas       = 2;
  localparam int unsigned TRp        = 2;
  localparam int unsigned TRasRef    = 3;
  localparam int unsigned RefPer     = 64;
  localparam int unsigned RefPerFast = 8;
  localparam int unsigned AckLat     = TRcd + TCas + 1;
  localparam int unsigned AccLen     = TRcd + TCas + TRp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance signals
  logic        reset, req, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, data_in;
  logic        ack, busy, rdata_valid, ras_n, cas_n, we_n, data_oe;
  logic [7:0]  rdata, maddress, data_out;

  // Fast-refresh instance signals
  logic        r_reset, r_req, r_req_we;
  logic [15:0] r_req_addr;
  logic [7:0]  r_req_wdata, r_data_in;
  logic        r_ack, r_busy, r_rdata_valid, r_ras_n, r_cas_n, r_we_n, r_data_oe;
  logic [7:0]  r_rdata, r_maddress, r_data_out;

  dram_master #(
    .T_RCD(TRcd), .T_CAS(TCas), .T_RP(TRp), .T_RAS_REF(TRasRef), .REFRESH_PERIOD(RefPer)
  ) u_dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
    .maddress(maddress), ._ras(ras_n), ._cas(cas_n), ._we(we_n), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in)
  );

  dram_master #(
    .T_RCD(TRcd), .T_CAS(TCas), .T_RP(TRp), .T_RAS_REF(TRasRef), .REFRESH_PERIOD(RefPerFast)
  ) u_ref (
    .clock(clock), .reset(r_reset), .req(r_req), .req_we(r_req_we), .req_addr(r_req_addr),
    .req_wdata(r_req_wdata), .ack(r_ack), .busy(r_busy), .rdata(r_rdata),
    .rdata_valid(r_rdata_valid), .maddress(r_maddress), ._ras(r_ras_n), ._cas(r_cas_n),
    ._we(r_we_n), .data_out(r_data_out), .data_oe(r_data_oe), .data_in(r_data_in)
  );

  typedef struct {
    int         ack_cyc;
    bit         rd;
    logic [7:0] data;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_ack_cyc = -1;

  // Responder model state
  logic [7:0] mem [0:65535];
  logic [7:0] row_lat = 8'h00;
  logic       ras_prev = 1'b1;

  // Refresh monitor state
  bit         r_active = 1'b0;
  int         r_c0 = 0;
  int         r_nref = 0;
  int         r_len = 0;
  logic [7:0] r_row_exp = 8'h00;
  logic       r_prev_ras = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon_main();
    exp_t e;
    if (ack || rdata_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {30'b0, ack, rdata_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_ack_cycle"}, cyc, e.ack_cyc);
        chk({e.tag, "_ack"}, {31'b0, ack}, 32'd1);
        chk({e.tag, "_rdata_valid"}, {31'b0, rdata_valid}, {31'b0, e.rd});
        if (e.rd) chk({e.tag, "_rdata"}, {24'b0, rdata}, {24'b0, e.data});
        last_ack_cyc = cyc;
      end
    end else if (sb.size() > 0 && cyc > sb[0].ack_cyc) begin
      e = sb.pop_front();
      chk({e.tag, "_missing_ack"}, {31'b0, ack}, 32'd1);
    end
  endtask

  task automatic mon_ref();
    if (!r_active) return;
    chk("ref_cas_ack_idle", {30'b0, r_cas_n, r_ack}, 32'd2);
    if (!r_ras_n && r_prev_ras) begin
      chk("ref_start_cycle", cyc - r_c0, RefPerFast + 1 + RefPerFast * r_nref);
      chk("ref_row", {24'b0, r_maddress}, {24'b0, r_row_exp});
      r_len = 1;
    end else if (!r_ras_n) begin
      r_len++;
    end else if (!r_prev_ras) begin
      chk("ref_ras_len", r_len, TRasRef);
      r_row_exp = r_row_exp + 8'd1;
      r_nref++;
    end
    r_prev_ras = r_ras_n;
  endtask

  // One clock: sample #1 after the edge, update the responder, run the monitors.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (!ras_n && ras_prev) row_lat = maddress;
    ras_prev = ras_n;
    if (!ras_n && !cas_n) begin
      if (!we_n) mem[{maddress, row_lat}] = data_out;
      data_in = mem[{maddress, row_lat}];
    end else begin
      data_in = 8'hEE;
    end
    mon_main();
    mon_ref();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {25'b0, ras_n, cas_n, we_n, ack, rdata_valid, busy, data_oe},
        32'h70);
    chk({tag, "_maddr_dout"}, {16'b0, maddress, data_out}, 32'd0);
    chk({tag, "_rdata"}, {24'b0, rdata}, 32'd0);
  endtask

  task automatic set_req(input logic [15:0] a, input logic w, input logic [7:0] wd);
    req       = 1'b1;
    req_addr  = a;
    req_we    = w;
    req_wdata = wd;
  endtask

  // Current cycle is the acceptance cycle A; checks A+1 .. A+AccLen+1.
  task automatic access_phases(input string tag, input logic [15:0] a, input logic w,
                               input logic [7:0] wd, input logic [7:0] rexp);
    exp_t e;
    e.ack_cyc = cyc + AckLat;
    e.rd      = !w;
    e.data    = rexp;
    e.tag     = tag;
    sb.push_back(e);
    for (int d = 1; d <= AccLen + 1; d++) begin
      tick();
      if (d <= TRcd) begin
        chk({tag, "_ras_phase"}, {27'b0, ras_n, cas_n, we_n, data_oe, busy}, 32'b01101);
        chk({tag, "_row"}, {24'b0, maddress}, {24'b0, a[7:0]});
      end else if (d <= TRcd + TCas) begin
        chk({tag, "_cas_phase"}, {27'b0, ras_n, cas_n, we_n, data_oe, busy},
            {27'b0, 1'b0, 1'b0, ~w, w, 1'b1});
        chk({tag, "_col"}, {24'b0, maddress}, {24'b0, a[15:8]});
        if (w) chk({tag, "_data_out"}, {24'b0, data_out}, {24'b0, wd});
      end else if (d <= AccLen) begin
        chk({tag, "_pre_phase"}, {27'b0, ras_n, cas_n, we_n, data_oe, busy}, 32'b11101);
        if (d == TRcd + TCas + 1) req = 1'b0;
      end else begin
        chk({tag, "_idle"}, {30'b0, ras_n, busy}, 32'b10);
      end
    end
  endtask

  initial begin : stim
    int c0;
    int rise;
    reset       = 1'b1;
    r_reset     = 1'b1;
    req         = 1'b1;
    req_we      = 1'b0;
    req_addr    = 16'h0000;
    req_wdata   = 8'h00;
    data_in     = 8'h00;
    r_req       = 1'b0;
    r_req_we    = 1'b0;
    r_req_addr  = 16'h0000;
    r_req_wdata = 8'h00;
    r_data_in   = 8'h00;
    mem[16'h0000] = 8'hA5;
    mem[16'h12C4] = 8'h5A;
    mem[16'hFF01] = 8'hC3;
    mem[16'hBEEF] = 8'h77;

    // Reset held 3 clocks with req high: nothing may move.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_vals("reset_hold");
    end
    reset    = 1'b0;
    r_reset  = 1'b0;
    r_active = 1'b1;
    r_c0     = cyc;
    // The still-pending request is accepted in the first cycle out of reset.
    access_phases("post_reset_read", 16'h0000, 1'b0, 8'h00, 8'hA5);

    set_req(16'h12C4, 1'b0, 8'h00);
    access_phases("read_12c4", 16'h12C4, 1'b0, 8'h00, 8'h5A);

    set_req(16'hD020, 1'b1, 8'h3A);
    access_phases("write_d020", 16'hD020, 1'b1, 8'h3A, 8'h00);
    chk("mem_d020", {24'b0, mem[16'hD020]}, 32'h3A);

    set_req(16'hD020, 1'b0, 8'h00);
    access_phases("readback_d020", 16'hD020, 1'b0, 8'h00, 8'h3A);

    set_req(16'h00FF, 1'b1, 8'hC6);
    access_phases("write_00ff", 16'h00FF, 1'b1, 8'hC6, 8'h00);
    chk("mem_00ff", {24'b0, mem[16'h00FF]}, 32'hC6);

    // Abort: reset during CAS of a read drops it with no ack.
    set_req(16'h12C4, 1'b0, 8'h00);
    for (int i = 0; i < TRcd + 1; i++) tick();
    chk("abort_in_cas", {30'b0, ras_n, cas_n}, 32'd0);
    reset = 1'b1;
    req   = 1'b0;
    tick();
    chk_reset_vals("abort_reset");
    reset = 1'b0;
    c0    = cyc;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_quiet", {30'b0, ras_n, busy}, 32'b10);
    end
    set_req(16'hFF01, 1'b0, 8'h00);
    access_phases("read_after_abort", 16'hFF01, 1'b0, 8'h00, 8'hC3);

    // Collision: req raised in the first cycle refresh is owed (cycle RefPer after release).
    while (cyc < c0 + RefPer) tick();
    set_req(16'hBEEF, 1'b0, 8'h00);
    rise = cyc;
    for (int d = 1; d <= TRasRef + TRp + 1; d++) begin
      tick();
      if (d <= TRasRef) begin
        chk("coll_ref_strobes", {30'b0, ras_n, cas_n}, 32'b01);
        chk("coll_ref_row", {24'b0, maddress}, 32'd0);
      end else if (d <= TRasRef + TRp) begin
        chk("coll_ref_pre", {30'b0, ras_n, cas_n}, 32'b11);
      end
    end
    access_phases("coll_read", 16'hBEEF, 1'b0, 8'h00, 8'h77);
    chk("coll_ack_latency", last_ack_cyc - rise, 1 + TRasRef + TRp + AckLat);

    // Let the fast instance run through a full row wrap and beyond.
    while (r_nref < 260 && cyc < r_c0 + 260 * RefPerFast + 100) tick();
    chk("ref_count", r_nref, 260);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
